hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_if.sv | 37 +++
 rtl/hazard_control_unit.sv | 139 +++++++++++++
 tb/tb_hazard_control_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Purpose: bundles the hazard inputs, pipeline strobes and perf counter of hazard_control_unit.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; freeze/bubble/flush_mask are the back-pressure outputs carried here.
// Ports: master = pipeline side (drives hazard inputs, receives strobes),
//        slave  = hazard unit side (receives hazard inputs, drives strobes, counter and state).
interface hazard_control_unit_if #(
    parameter int REG_W        = 5,
    parameter int FLUSH_STAGES = 3,
    parameter int CNT_W        = 16
);
    logic                    dx_memRead;
    logic [REG_W-1:0]        dx_rd;
    logic [REG_W-1:0]        fd_rs1;
    logic [REG_W-1:0]        fd_rs2;
    logic                    fd_uses_rs2;
    logic                    branch_taken;
    logic                    jump;
    logic                    dmem_busy;
    logic                    perf_clr;
    logic                    freeze;
    logic                    bubble;
    logic [FLUSH_STAGES-1:0] flush_mask;
    logic [CNT_W-1:0]        stall_count;
    logic [1:0]              state;

    modport master (
        output dx_memRead, dx_rd, fd_rs1, fd_rs2, fd_uses_rs2,
               branch_taken, jump, dmem_busy, perf_clr,
        input  freeze, bubble, flush_mask, stall_count, state
    );

    modport slave (
        input  dx_memRead, dx_rd, fd_rs1, fd_rs2, fd_uses_rs2,
               branch_taken, jump, dmem_busy, perf_clr,
        output freeze, bubble, flush_mask, stall_count, state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Purpose: pipeline hazard controller: load-use stalls, branch/jump flushes, data-memory waits.
// Latency: freeze/bubble/flush_mask are same-cycle (Mealy); state and stall_count update on the next edge.
// Backpressure: dmem_busy outranks redirect, which outranks load-use; freeze holds PC and fetch/decode.
// Ports: CLK, RST (synchronous, active high); bus (slave modport) carries the decode/execute and
//        fetch/decode register indices, branch_taken/jump, dmem_busy, perf_clr in, and
//        freeze, bubble, flush_mask, stall_count, state out.
module hazard_control_unit #(
    parameter int REG_W        = 5,
    parameter int LU_STALL     = 1,
    parameter int FLUSH_STAGES = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    hazard_control_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU       = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    // Reload values are "remaining cycles after this one"; a single-cycle
    // stall or flush never leaves RUN.
    localparam logic [1:0] LU_RELOAD = 2'(LU_STALL - 1);
    localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam state_t     LU_NEXT   = (LU_STALL > 1)     ? ST_LU    : ST_RUN;
    localparam state_t     FL_NEXT   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    localparam logic [FLUSH_STAGES-1:0] MASK_ALL  = '1;
    localparam logic [FLUSH_STAGES-1:0] MASK_FD   = FLUSH_STAGES'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = '1;

    state_t                  st;
    state_t                  st_nxt;
    logic [1:0]              cnt;
    logic [1:0]              cnt_nxt;
    logic [CNT_W-1:0]        stall_cnt;
    logic                    freeze_c;
    logic                    bubble_c;
    logic [FLUSH_STAGES-1:0] mask_c;
    logic                    lu_hit;
    logic                    redirect;

    // Register 0 is hard-wired zero, so it can never carry a load-use dependency.
    assign lu_hit = bus.dx_memRead && (bus.dx_rd != '0) &&
                    ((bus.dx_rd == bus.fd_rs1) ||
                     (bus.fd_uses_rs2 && (bus.dx_rd == bus.fd_rs2)));
    assign redirect = bus.branch_taken || bus.jump;

    always_comb begin
        freeze_c = 1'b0;
        bubble_c = 1'b0;
        mask_c   = '0;
        st_nxt   = st;
        cnt_nxt  = cnt;
        // Strobes stay quiet while reset is held; the sequential block
        // discards st_nxt/cnt_nxt in that case.
        if (!RST) begin
            case (st)
                ST_RUN, ST_LU: begin
                    if (bus.dmem_busy) begin
                        // Any pending load-use count is dropped; the pipeline
                        // re-evaluates the hazard once memory returns.
                        freeze_c = 1'b1;
                        st_nxt   = ST_MEM_WAIT;
                    end else if (redirect) begin
                        mask_c  = MASK_ALL;
                        st_nxt  = FL_NEXT;
                        cnt_nxt = FL_RELOAD;
                    end else if (st == ST_LU) begin
                        freeze_c = 1'b1;
                        bubble_c = 1'b1;
                        cnt_nxt  = cnt - 2'd1;
                        if (cnt == 2'd1) begin
                            st_nxt = ST_RUN;
                        end
                    end else if (lu_hit) begin
                        freeze_c = 1'b1;
                        bubble_c = 1'b1;
                        st_nxt   = LU_NEXT;
                        cnt_nxt  = LU_RELOAD;
                    end
                end
                ST_MEM_WAIT: begin
                    // A redirect held by the frozen pipeline is seen again in RUN.
                    if (bus.dmem_busy) begin
                        freeze_c = 1'b1;
                    end else begin
                        st_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // The fetch/decode instruction is being squashed, so a
                    // load-use match against it is meaningless here.
                    if (bus.dmem_busy) begin
                        freeze_c = 1'b1;
                    end else if (redirect) begin
                        mask_c  = MASK_ALL;
                        cnt_nxt = FL_RELOAD;
                    end else begin
                        mask_c  = MASK_FD;
                        cnt_nxt = cnt - 2'd1;
                        if (cnt == 2'd1) begin
                            st_nxt = ST_RUN;
                        end
                    end
                end
                default: st_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st        <= ST_RUN;
            cnt       <= 2'd0;
            stall_cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            // Clear wins over a simultaneous freeze cycle.
            if (bus.perf_clr) begin
                stall_cnt <= '0;
            end else if (freeze_c && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.freeze      = freeze_c;
    assign bus.bubble      = bubble_c;
    assign bus.flush_mask  = mask_c;
    assign bus.stall_count = stall_cnt;
    assign bus.state       = st;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose: self-checking bench for hazard_control_unit: directed scenarios then random traffic vs a reference model.
// Latency: strobes checked 1 time unit after inputs settle; model advances once per clock.
// Backpressure: dmem_busy is driven randomly and in directed bursts.
module tb_hazard_control_unit;

    localparam int REG_W = 5;
    localparam int LS    = 2;
    localparam int FS    = 3;
    localparam int FC    = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    hazard_control_unit_if #(.REG_W(REG_W), .FLUSH_STAGES(FS), .CNT_W(CW)) hif ();

    hazard_control_unit #(
        .REG_W(REG_W), .LU_STALL(LS), .FLUSH_STAGES(FS),
        .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (hif)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    // Reference model: remaining stall / flush cycles, a memory-wait flag and the perf count.
    int m_lu  = 0;
    int m_fl  = 0;
    bit m_mw  = 1'b0;
    int m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_cycle(input bit r, input bit mr, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input bit u2,
                            input bit bt, input bit jp, input bit busy, input bit pc);
        bit f;
        bit b;
        logic [2:0] m;
        bit lu;
        bit rdr;
        int exp_st;
        int exp_cnt;
        f = 1'b0;
        b = 1'b0;
        m = 3'b000;
        @(negedge CLK);
        RST              = r;
        hif.dx_memRead   = mr;
        hif.dx_rd        = rd;
        hif.fd_rs1       = rs1;
        hif.fd_rs2       = rs2;
        hif.fd_uses_rs2  = u2;
        hif.branch_taken = bt;
        hif.jump         = jp;
        hif.dmem_busy    = busy;
        hif.perf_clr     = pc;
        #1;
        exp_st  = m_mw ? 3 : (m_fl > 0) ? 2 : (m_lu > 0) ? 1 : 0;
        exp_cnt = m_cnt;
        lu  = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
        rdr = bt || jp;
        if (!r) begin
            if (m_mw) begin
                if (busy) f = 1'b1;
                else m_mw = 1'b0;
            end else if (m_fl > 0) begin
                if (busy) f = 1'b1;
                else if (rdr) begin m = 3'b111; m_fl = FC - 1; end
                else begin m = 3'b001; m_fl--; end
            end else begin
                if (busy) begin f = 1'b1; m_mw = 1'b1; m_lu = 0; end
                else if (rdr) begin m = 3'b111; m_fl = FC - 1; m_lu = 0; end
                else if (m_lu > 0) begin f = 1'b1; b = 1'b1; m_lu--; end
                else if (lu) begin f = 1'b1; b = 1'b1; m_lu = LS - 1; end
            end
        end
        chk("freeze",      32'(hif.freeze),      32'(f));
        chk("bubble",      32'(hif.bubble),      32'(b));
        chk("flush_mask",  32'(hif.flush_mask),  32'(m));
        chk("state",       32'(hif.state),       32'(exp_st));
        chk("stall_count", 32'(hif.stall_count), 32'(exp_cnt));
        if (r) begin
            m_lu = 0; m_fl = 0; m_mw = 1'b0; m_cnt = 0;
        end else if (pc) begin
            m_cnt = 0;
        end else if (f && (m_cnt < CMAX)) begin
            m_cnt++;
        end
    endtask

    task automatic idle();
        do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset with noisy inputs: strobes must stay low throughout.
        do_cycle(1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0);
        do_cycle(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
        idle();
        chk("reset_state", 32'(hif.state), 32'd0);
        chk("reset_count", 32'(hif.stall_count), 32'd0);

        // Load-use on rs2: two stall cycles, back to RUN.
        do_cycle(0, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, 0);
        do_cycle(0, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, 0);
        idle();
        chk("lu_stall_count", 32'(hif.stall_count), 32'd2);

        // False hazards: x0 destination, and rs2 match without rs2 use.
        do_cycle(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        do_cycle(0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, 0);

        // Jump: full mask, then two fetch-only flushes, then quiet.
        do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        idle();
        idle();
        idle();

        // Branch held under a 4-cycle memory wait, acted on once RUN resumes.
        repeat (4) do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0);
        do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
        do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
        chk("redirect_after_wait", 32'(hif.flush_mask), 32'h7);
        repeat (3) idle();

        // Saturation then clear.
        do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        repeat (20) do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        idle();
        chk("sat_count", 32'(hif.stall_count), 32'd15);
        do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        idle();
        chk("clr_count", 32'(hif.stall_count), 32'd0);

        // Reset in the middle of LU and of FLUSH.
        do_cycle(0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0);
        idle();
        chk("rst_lu_state", 32'(hif.state), 32'd0);
        do_cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
        do_cycle(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        idle();
        chk("rst_fl_state", 32'(hif.state), 32'd0);
        chk("rst_fl_mask", 32'(hif.flush_mask), 32'd0);

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom_range(0, 99) < 2),
                     $urandom_range(0, 1),
                     5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)),
                     $urandom_range(0, 1),
                     ($urandom_range(0, 99) < 8),
                     ($urandom_range(0, 99) < 5),
                     ($urandom_range(0, 99) < 20),
                     ($urandom_range(0, 99) < 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
